// File: rtl/hazard_pkg.sv
// Shared bypass encodings and controller states for the
// hazard/forwarding unit of the 5-stage pipeline.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_E  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b11;

    typedef enum logic [1:0] {
        RUN,
        LDUSE,
        MEMWAIT
    } state_e;

endpackage

// File: rtl/fwd_select.sv
// Bypass select for one D-stage source operand.
// Youngest matching producer wins: E, then M, then W.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] iSrc,
    input  logic              iRegWrite_E,
    input  logic [REG_AW-1:0] iWsel_E,
    input  logic              iRegWrite_M,
    input  logic [REG_AW-1:0] iWsel_M,
    input  logic              iRegWrite_W,
    input  logic [REG_AW-1:0] iWsel_W,
    output logic [1:0]        oSel,
    output logic              oMatch_E
);

    logic w_hit_e;
    logic w_hit_m;
    logic w_hit_w;

    // r0 is hard-wired, so a zero destination never matches
    assign w_hit_e = iRegWrite_E && (iWsel_E != '0) && (iWsel_E == iSrc);
    assign w_hit_m = iRegWrite_M && (iWsel_M != '0) && (iWsel_M == iSrc);
    assign w_hit_w = iRegWrite_W && (iWsel_W != '0) && (iWsel_W == iSrc);

    assign oMatch_E = w_hit_e;

    always_comb begin
        oSel = FWD_RF;
        if (w_hit_e) begin
            oSel = FWD_E;
        end else if (w_hit_m) begin
            oSel = FWD_M;
        end else if (w_hit_w) begin
            oSel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding select, load-use bubble insertion and memory-busy
// freeze for the F/D/E/M/W pipeline, with a stall-cycle counter.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] iSrc_RegD,
    input  logic [NUM_SRC-1:0]        iSrcUsed_RegD,
    input  logic                      iRegWrite_RegE,
    input  logic                      iMemRead_RegE,
    input  logic [REG_AW-1:0]         iwsel_RegE,
    input  logic                      iRegWrite_RegM,
    input  logic [REG_AW-1:0]         iwsel_RegM,
    input  logic                      iRegWrite_RegW,
    input  logic [REG_AW-1:0]         iwsel_RegW,
    input  logic                      iMemBusy,
    input  logic                      iCntClr,
    output logic [NUM_SRC*2-1:0]      oFU_Sel,
    output logic                      oStall_F,
    output logic                      oStall_D,
    output logic                      oStall_E,
    output logic                      oStall_M,
    output logic                      oFlush_E,
    output logic [CNT_W-1:0]          oStallCnt
);

    localparam int BW = $clog2(LOAD_LAT + 1);

    logic [NUM_SRC-1:0] w_ematch;
    logic               w_ldhaz;
    state_e             r_state;
    state_e             w_state_nxt;
    state_e             w_eff;
    logic [BW-1:0]      r_bcnt;
    logic [BW-1:0]      w_bcnt_nxt;
    logic               w_hold;
    logic               w_bub;
    logic [CNT_W-1:0]   r_cnt;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
        fwd_select #(.REG_AW(REG_AW)) u_fwd (
            .iSrc        (iSrc_RegD[k*REG_AW +: REG_AW]),
            .iRegWrite_E (iRegWrite_RegE),
            .iWsel_E     (iwsel_RegE),
            .iRegWrite_M (iRegWrite_RegM),
            .iWsel_M     (iwsel_RegM),
            .iRegWrite_W (iRegWrite_RegW),
            .iWsel_W     (iwsel_RegW),
            .oSel        (oFU_Sel[2*k +: 2]),
            .oMatch_E    (w_ematch[k])
        );
    end

    assign w_ldhaz = iMemRead_RegE && iRegWrite_RegE &&
                     (iwsel_RegE != '0) &&
                     (|(iSrcUsed_RegD & w_ematch));

    // The cycle busy drops behaves exactly like the state being resumed
    always_comb begin
        w_eff = r_state;
        if (r_state == MEMWAIT && !iMemBusy) begin
            w_eff = (r_bcnt != '0) ? LDUSE : RUN;
        end
        w_state_nxt = w_eff;
        w_bcnt_nxt  = r_bcnt;
        w_hold      = 1'b0;
        w_bub       = 1'b0;
        if (iMemBusy) begin
            w_state_nxt = MEMWAIT;
            w_hold      = 1'b1;
        end else begin
            case (w_eff)
                RUN: begin
                    if (w_ldhaz) begin
                        w_bub       = 1'b1;
                        w_bcnt_nxt  = BW'(LOAD_LAT - 1);
                        w_state_nxt = (LOAD_LAT > 1) ? LDUSE : RUN;
                    end
                end
                LDUSE: begin
                    w_bub      = 1'b1;
                    w_bcnt_nxt = r_bcnt - BW'(1);
                    if (r_bcnt == BW'(1)) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (iCntClr) begin
            r_cnt <= '0;
        end else if ((w_hold || w_bub) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Gate with reset so an abort mid-bubble or mid-freeze is immediate
    assign oStall_F  = rst_n && (w_hold || w_bub);
    assign oStall_D  = rst_n && (w_hold || w_bub);
    assign oStall_E  = rst_n && w_hold;
    assign oStall_M  = rst_n && w_hold;
    assign oFlush_E  = rst_n && w_bub;
    assign oStallCnt = r_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: one instance with LOAD_LAT=1/CNT_W=4,
// one with LOAD_LAT=3/CNT_W=16, driven from a shared vector table.
module tb_hazard_forward_ctrl;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] src;
    logic [1:0] used;
    logic       we_e, mr_e, we_m, we_w, busy, clr;
    logic [4:0] ws_e, ws_m, ws_w;

    logic [3:0]  sel1, sel3;
    logic        f1, d1, e1, m1, fl1;
    logic        f3, d3, e3, m3, fl3;
    logic [3:0]  cnt1;
    logic [15:0] cnt3;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        bit         pre_rst;
        int         which;
        logic [4:0] s0, s1;
        logic [1:0] used;
        logic       we_e, mr_e;
        logic [4:0] ws_e;
        logic       we_m;
        logic [4:0] ws_m;
        logic       we_w;
        logic [4:0] ws_w;
        logic       busy, clr;
        logic [3:0] x_sel;
        logic [4:0] x_ctl;
        int         x_cnt;
    } vec_t;

    typedef struct {
        int         which;
        string      tag;
        logic [3:0] sel;
        logic [4:0] ctl;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];

    hazard_forward_ctrl #(
        .NUM_SRC(2), .REG_AW(5), .LOAD_LAT(1), .CNT_W(4)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .iSrc_RegD(src), .iSrcUsed_RegD(used),
        .iRegWrite_RegE(we_e), .iMemRead_RegE(mr_e), .iwsel_RegE(ws_e),
        .iRegWrite_RegM(we_m), .iwsel_RegM(ws_m),
        .iRegWrite_RegW(we_w), .iwsel_RegW(ws_w),
        .iMemBusy(busy), .iCntClr(clr),
        .oFU_Sel(sel1),
        .oStall_F(f1), .oStall_D(d1), .oStall_E(e1), .oStall_M(m1),
        .oFlush_E(fl1), .oStallCnt(cnt1)
    );

    hazard_forward_ctrl #(
        .NUM_SRC(2), .REG_AW(5), .LOAD_LAT(3), .CNT_W(16)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .iSrc_RegD(src), .iSrcUsed_RegD(used),
        .iRegWrite_RegE(we_e), .iMemRead_RegE(mr_e), .iwsel_RegE(ws_e),
        .iRegWrite_RegM(we_m), .iwsel_RegM(ws_m),
        .iRegWrite_RegW(we_w), .iwsel_RegW(ws_w),
        .iMemBusy(busy), .iCntClr(clr),
        .oFU_Sel(sel3),
        .oStall_F(f3), .oStall_D(d3), .oStall_E(e3), .oStall_M(m3),
        .oFlush_E(fl3), .oStallCnt(cnt3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int ctl_of(int w);
        if (w == 1) return int'({f1, d1, e1, m1, fl1});
        return int'({f3, d3, e3, m3, fl3});
    endfunction

    function automatic int sel_of(int w);
        if (w == 1) return int'(sel1);
        return int'(sel3);
    endfunction

    function automatic int cnt_of(int w);
        if (w == 1) return int'(cnt1);
        return int'(cnt3);
    endfunction

    function automatic vec_t V(bit r, int w, int s0, int s1, int u,
                               int wee, int mre, int wse,
                               int wem, int wsm, int wew, int wsw,
                               int bz, int cl, int xs, int xc, int xn);
        vec_t v;
        v.pre_rst = r;
        v.which = w;
        v.s0 = 5'(s0);
        v.s1 = 5'(s1);
        v.used = 2'(u);
        v.we_e = 1'(wee);
        v.mr_e = 1'(mre);
        v.ws_e = 5'(wse);
        v.we_m = 1'(wem);
        v.ws_m = 5'(wsm);
        v.we_w = 1'(wew);
        v.ws_w = 5'(wsw);
        v.busy = 1'(bz);
        v.clr = 1'(cl);
        v.x_sel = 4'(xs);
        v.x_ctl = 5'(xc);
        v.x_cnt = xn;
        return v;
    endfunction

    task automatic zero_inputs();
        src = '0; used = '0;
        we_e = 0; mr_e = 0; ws_e = '0;
        we_m = 0; ws_m = '0; we_w = 0; ws_w = '0;
        busy = 0; clr = 0;
    endtask

    task automatic check_reset(string tag);
        for (int w = 1; w <= 3; w += 2) begin
            chk($sformatf("%s_ctl%0d", tag, w), ctl_of(w), 0);
            chk($sformatf("%s_cnt%0d", tag, w), cnt_of(w), 0);
        end
    endtask

    task automatic do_reset(string tag);
        rst_n = 1'b0;
        zero_inputs();
        #1;
        check_reset(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        src  = {v.s1, v.s0};
        used = v.used;
        we_e = v.we_e; mr_e = v.mr_e; ws_e = v.ws_e;
        we_m = v.we_m; ws_m = v.ws_m;
        we_w = v.we_w; ws_w = v.ws_w;
        busy = v.busy; clr = v.clr;
        exp_q.push_back('{v.which, tag, v.x_sel, v.x_ctl, v.x_cnt});
        @(negedge clk);
        e = exp_q.pop_front();
        chk({e.tag, "_sel"}, sel_of(e.which), int'(e.sel));
        chk({e.tag, "_ctl"}, ctl_of(e.which), int'(e.ctl));
        if (e.cnt >= 0) chk({e.tag, "_cnt"}, cnt_of(e.which), e.cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        // r w  s0 s1 u  we mr wse wem wsm wew wsw bz cl sel     ctl       cnt
        tbl.push_back(V(0,1, 3,0,0, 1,0,3, 1,3, 0,0, 0,0, 4'b0010,5'b00000,0));
        tbl.push_back(V(0,1, 3,0,0, 0,0,3, 1,3, 0,0, 0,0, 4'b0001,5'b00000,0));
        tbl.push_back(V(0,1, 3,0,0, 0,0,0, 0,0, 1,3, 0,0, 4'b0011,5'b00000,0));
        tbl.push_back(V(0,1, 5,0,0, 1,0,0, 1,0, 1,0, 0,0, 4'b0000,5'b00000,0));
        tbl.push_back(V(0,1, 7,7,0, 1,0,7, 1,9, 1,9, 0,0, 4'b1010,5'b00000,0));
        tbl.push_back(V(0,1, 2,9,0, 0,0,0, 1,9, 1,2, 0,0, 4'b0111,5'b00000,0));
        tbl.push_back(V(0,1, 0,4,0, 0,0,4, 0,4, 0,4, 0,0, 4'b0000,5'b00000,0));
        tbl.push_back(V(0,1, 6,6,3, 0,1,6, 1,6, 1,6, 0,0, 4'b0101,5'b00000,0));
        tbl.push_back(V(0,1, 0,4,2, 1,1,4, 0,0, 0,0, 0,0, 4'b1000,5'b11001,0));
        tbl.push_back(V(0,1, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 4'b0000,5'b00000,1));
        tbl.push_back(V(0,1, 0,4,1, 1,1,4, 0,0, 0,0, 0,0, 4'b1000,5'b00000,1));
        tbl.push_back(V(0,1, 0,0,2, 1,1,0, 0,0, 0,0, 0,0, 4'b0000,5'b00000,1));
        tbl.push_back(V(1,3, 0,4,2, 1,1,4, 0,0, 0,0, 0,0, 4'b1000,5'b11001,0));
        tbl.push_back(V(0,3, 0,0,0, 0,0,0, 0,0, 0,0, 1,0, 4'b0000,5'b11110,1));
        tbl.push_back(V(0,3, 0,0,0, 0,0,0, 0,0, 0,0, 1,0, 4'b0000,5'b11110,2));
        tbl.push_back(V(0,3, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 4'b0000,5'b11001,3));
        tbl.push_back(V(0,3, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 4'b0000,5'b11001,4));
        tbl.push_back(V(0,3, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 4'b0000,5'b00000,5));
        tbl.push_back(V(0,3, 0,4,2, 1,1,4, 0,0, 0,0, 0,0, 4'b1000,5'b11001,5));
        tbl.push_back(V(0,3, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 4'b0000,5'b11001,6));
        tbl.push_back(V(0,3, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 4'b0000,5'b11001,7));
        tbl.push_back(V(0,3, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 4'b0000,5'b00000,8));
        tbl.push_back(V(1,1, 0,4,2, 1,1,4, 0,0, 0,0, 1,0, 4'b1000,5'b11110,0));
        tbl.push_back(V(0,1, 0,4,2, 1,1,4, 0,0, 0,0, 0,0, 4'b1000,5'b11001,1));
        tbl.push_back(V(0,1, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 4'b0000,5'b00000,2));

        rst_n = 1'b0;
        zero_inputs();
        #2;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            if (tbl[i].pre_rst) do_reset($sformatf("rst%0d", i));
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // 4-bit counter saturates under a long memory freeze
        for (int i = 0; i < 20; i++) begin
            v = V(0,1, 0,0,0, 0,0,0, 0,0, 0,0, 1,0, 0, 5'b11110,
                  (2 + i > 15) ? 15 : 2 + i);
            apply(v, $sformatf("sat%0d", i));
        end
        apply(V(0,1, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 0,5'b00000,15), "sat_hold");
        apply(V(0,1, 0,0,0, 0,0,0, 0,0, 0,0, 1,1, 0,5'b11110,15), "clr_stall");
        apply(V(0,1, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 0,5'b00000,0), "clr_after");

        // Reset asserted while frozen must drop every stall at once
        apply(V(0,1, 0,0,0, 0,0,0, 0,0, 0,0, 1,0, 0,5'b11110,0), "mw_enter");
        rst_n = 1'b0;
        #1;
        check_reset("mw_rst");
        @(negedge clk);
        rst_n = 1'b1;
        busy = 1'b0;
        @(posedge clk);
        #1;
        apply(V(0,1, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 0,5'b00000,0), "mw_post1");
        apply(V(0,3, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 0,5'b00000,0), "mw_post3");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
